if_id_skid_stage: RTL and testbench

- Parametrised IF/ID pipeline stage register with a ready/valid handshake, a 2-entry skid buffer, flush-to-bubble and a stall-cycle counter.
- Sits between instruction fetch and decode; replaces the single-entry write-enabled IF/ID latch.
- Downstream back-pressure (hazard unit, multicycle decode) never loses a fetched instruction, and in_ready depends only on registered state, so there is no combinational ready path from decode to fetch.

---
 rtl/if_id_skid_stage.sv | 85 ++++++++
 tb/tb_if_id_skid_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a two-entry skid buffer, flush-to-bubble and
// a saturating stall-cycle counter. in_ready comes straight from a flop.
module if_id_skid_stage #(
  parameter int                   PC_W      = 32,
  parameter int                   INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  parameter int                   CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc4,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; a producer holding valid=1 keeps its data stable until accepted.
  logic               skid_valid;
  logic [PC_W-1:0]    skid_pc4;
  logic [INSTR_W-1:0] skid_instr;

  logic in_fire;
  logic main_free;
  logic stalled;

  assign in_ready  = ~skid_valid;
  assign in_fire   = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;
  assign stalled   = out_valid & ~out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc4    <= '0;
      out_instr  <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc4   <= '0;
      skid_instr <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      // Squash everything held and anything arriving this cycle.
      out_valid  <= 1'b0;
      out_pc4    <= '0;
      out_instr  <= NOP_INSTR;
      skid_valid <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (main_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_pc4    <= skid_pc4;
          out_instr  <= skid_instr;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          out_valid  <= 1'b1;
          out_pc4    <= in_pc4;
          out_instr  <= in_instr;
        end else begin
          out_valid  <= 1'b0;
          out_pc4    <= '0;
          out_instr  <= NOP_INSTR;
        end
      end else if (in_fire) begin
        // Main is stalled: park the arriving instruction so it is not lost.
        skid_valid <= 1'b1;
        skid_pc4   <= in_pc4;
        skid_instr <= in_instr;
      end

      if (stalled) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: streaming, stall/skid, flush,
// counter saturation and asynchronous reset.
module tb_if_id_skid_stage;
  localparam int               PC_W    = 32;
  localparam int               INSTR_W = 32;
  localparam int               CNT_W   = 3;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam int               VW      = 2 + CNT_W + PC_W + INSTR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [PC_W-1:0]    in_pc4 = '0;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc4;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready = 1'b0;
  logic               flush = 1'b0;
  logic [CNT_W-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];
  logic [VW-1:0]   got, want;

  if_id_skid_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc4(in_pc4),
    .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid),
    .out_pc4(out_pc4), .out_instr(out_instr), .out_ready(out_ready),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Instruction word the bench pairs with each PC+4.
  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return {pc[15:0], 16'hBEEF};
  endfunction

  // Packs {out_valid, in_ready, stall_cnt, out_pc4, out_instr}.
  function automatic logic [VW-1:0] pack(input logic v, input logic r,
      input logic [CNT_W-1:0] s, input logic [PC_W-1:0] p,
      input logic [INSTR_W-1:0] i);
    return {v, r, s, p, i};
  endfunction

  function automatic logic [VW-1:0] busy(input logic [PC_W-1:0] p,
      input logic r, input logic [CNT_W-1:0] s);
    return pack(1'b1, r, s, p, instr_of(p));
  endfunction

  function automatic logic [VW-1:0] empty();
    return pack(1'b0, 1'b1, '0, '0, NOP);
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [PC_W-1:0] pc,
      input logic ordy, input logic fl);
    in_valid  = v;
    in_pc4    = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    got = pack(out_valid, in_ready, stall_cnt, out_pc4, out_instr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(); step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL reset_state: got %h want %h", got, empty());
    end
    rst = 1'b0;
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL after_reset_idle: got %h want %h", got, empty());
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, PC_W'(4 * i), 1'b1, 1'b0);
      exp_q.push_back(PC_W'(4 * i));
      step();
      want = busy(exp_q.pop_front(), 1'b1, '0);
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL stream_%0d: got %h want %h", i, got, want);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL stream_drain: got %h want %h", got, empty());
    end
  endtask

  task automatic test_stall();
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    step();
    want = busy(exp_q.pop_front(), 1'b1, 3'd0);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL stall_load: got %h want %h", got, want);
    end
    // stall 1: 0x8 offered and parked in skid
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    step();
    want = busy(32'h4, 1'b0, 3'd1);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL stall_1: got %h want %h", got, want);
    end
    // stalls 2 and 3: 0xC waits at the input
    for (int i = 2; i <= 3; i++) begin
      drive(1'b1, 32'hC, 1'b0, 1'b0);
      step();
      want = busy(32'h4, 1'b0, CNT_W'(i));
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall_%0d: got %h want %h", i, got, want);
      end
    end
    // release: skid (0x8) moves to main, 0xC still not accepted
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    step();
    want = busy(exp_q.pop_front(), 1'b1, 3'd0);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL release_skid: got %h want %h", got, want);
    end
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    step();
    want = busy(exp_q.pop_front(), 1'b1, 3'd0);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL release_last: got %h want %h", got, want);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (got !== empty() || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain: got %h want %h", got, empty());
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    step();
    want = busy(32'h10, 1'b0, 3'd1);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL flush_fill: got %h want %h", got, want);
    end
    drive(1'b1, 32'h18, 1'b1, 1'b1);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL flush_full: got %h want %h", got, empty());
    end
    // flush while the stage accepts: the incoming 0x1C is discarded
    drive(1'b1, 32'h1C, 1'b1, 1'b1);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL flush_discard_in: got %h want %h", got, empty());
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      checks++;
      if (got !== empty()) begin
        errors++; $display("FAIL flush_quiet_%0d: got %h want %h", i, got, empty());
      end
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    want = busy(32'h20, 1'b1, 3'd1);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL flush_stall_hold: got %h want %h", got, want);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL flush_beats_stall: got %h want %h", got, empty());
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] s;
    drive(1'b1, 32'h30, 1'b1, 1'b0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      step();
      s = (i > 7) ? 3'd7 : CNT_W'(i);
      want = busy(32'h30, 1'b1, s);
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL sat_cycle_%0d: got %h want %h", i, got, want);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL sat_clear: got %h want %h", got, empty());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    want = busy(32'h40, 1'b0, 3'd1);
    got  = pack(out_valid, in_ready, stall_cnt, out_pc4, out_instr);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL pre_reset_full: got %h want %h", got, want);
    end
    rst = 1'b1;
    #1;
    got = pack(out_valid, in_ready, stall_cnt, out_pc4, out_instr);
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL async_reset: got %h want %h", got, empty());
    end
    #1;
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (got !== empty()) begin
      errors++; $display("FAIL post_reset_empty: got %h want %h", got, empty());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
